// File: rtl/score_display.sv
// score_display: converts the binary score to BCD one bit per clk3 cycle
// (shift-add-3), holds the finished digits in a register bank, and scans
// them onto a multiplexed active-low 7-segment display.
// Build option: define LEADZERO_BLANK_EN to blank zero digits above the
// most significant non-zero digit (the units digit always shows).
module score_display #(
  parameter int SCORE_W  = 14,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic                clk3,
  input  logic                reset,
  input  logic [SCORE_W-1:0]  score,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                busy,
  output logic                ovf
);

  // ceil(w*log10(2) + 1) in fixed point, so the accumulator never drops a carry
  function automatic int bcd_digits(input int w);
    int scaled;
    scaled = w * 30103 + 100000;
    return (scaled + 99999) / 100000;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam int BCD_N = bcd_digits(SCORE_W);
  localparam int BCD_W = 4 * BCD_N;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [63:0] MAX_SHOWN = pow10(DIGITS) - 64'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  // Add 3 to every nibble that is 5 or more, ahead of the next shift
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_N; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = r[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 is blank
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = 7'h7F;
    endcase
    return c;
  endfunction

  state_t                state_r, state_n;
  logic [SCORE_W-1:0]    last_r, last_n;
  logic [SCORE_W-1:0]    shift_r, shift_n;
  logic [BCD_W-1:0]      bcd_r, bcd_n, adj_s;
  logic [CNT_W-1:0]      bitcnt_r, bitcnt_n;
  logic                  busy_r, busy_n;
  logic                  ovf_r, ovf_n;
  logic [4*DIGITS-1:0]   digits_r, digits_n;

  logic [DIV_W-1:0]      div_r;
  logic [IDX_W-1:0]      idx_r;
  logic [6:0]            seg_r;
  logic [DIGITS-1:0]     an_r;
  logic [3:0]            cur_digit_s;
  logic [DIGITS-1:0]     an_s;
  logic                  blank_s;

  // Converter state and datapath registers
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      last_r   <= '0;
      shift_r  <= '0;
      bcd_r    <= '0;
      bitcnt_r <= '0;
      busy_r   <= 1'b0;
      ovf_r    <= 1'b0;
      digits_r <= '0;
    end else begin
      state_r  <= state_n;
      last_r   <= last_n;
      shift_r  <= shift_n;
      bcd_r    <= bcd_n;
      bitcnt_r <= bitcnt_n;
      busy_r   <= busy_n;
      ovf_r    <= ovf_n;
      digits_r <= digits_n;
    end
  end

  // Converter next-state: start on a new score, shift-add-3, then load digits
  always_comb begin
    state_n  = state_r;
    last_n   = last_r;
    shift_n  = shift_r;
    bcd_n    = bcd_r;
    bitcnt_n = bitcnt_r;
    busy_n   = busy_r;
    ovf_n    = ovf_r;
    digits_n = digits_r;
    adj_s    = add3(bcd_r);
    case (state_r)
      IDLE: begin
        if (score != last_r) begin
          shift_n  = score;
          last_n   = score;
          bcd_n    = '0;
          busy_n   = 1'b1;
          bitcnt_n = CNT_W'(SCORE_W);
          state_n  = CONV;
        end else begin
          state_n  = IDLE;
        end
      end
      CONV: begin
        {bcd_n, shift_n} = {adj_s[BCD_W-2:0], shift_r, 1'b0};
        bitcnt_n = bitcnt_r - CNT_W'(1);
        if (bitcnt_r == CNT_W'(1)) begin
          state_n = LOAD;
        end else begin
          state_n = CONV;
        end
      end
      LOAD: begin
        busy_n = 1'b0;
        // Saturate to all nines when the value cannot be shown
        if (64'(last_r) > MAX_SHOWN) begin
          ovf_n    = 1'b1;
          digits_n = {DIGITS{4'd9}};
        end else begin
          ovf_n    = 1'b0;
          digits_n = (4*DIGITS)'(bcd_r);
        end
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Pick the digit and anode pattern for the current scan position
  always_comb begin
    cur_digit_s = 4'd0;
    an_s        = '1;
    for (int i = 0; i < DIGITS; i++) begin
      cur_digit_s = cur_digit_s | ((idx_r == IDX_W'(i)) ? digits_r[4*i +: 4] : 4'd0);
      an_s[i]     = (idx_r == IDX_W'(i)) ? 1'b0 : 1'b1;
    end
  end

`ifdef LEADZERO_BLANK_EN
  logic lz_above_s;

  // Blank a digit when it and every digit above it are zero (never the units)
  always_comb begin
    lz_above_s = 1'b1;
    blank_s    = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_above_s = lz_above_s & (digits_r[4*i +: 4] == 4'd0);
      blank_s    = blank_s | ((idx_r == IDX_W'(i)) & lz_above_s & ~ovf_r);
    end
  end
`else
  assign blank_s = 1'b0;
`endif

  // Refresh scanner: dwell SCAN_DIV cycles per digit, outputs registered
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      div_r <= '0;
      idx_r <= '0;
      seg_r <= 7'h7F;
      an_r  <= '1;
    end else begin
      seg_r <= blank_s ? 7'h7F : seg_code(cur_digit_s);
      an_r  <= an_s;
      if (div_r == DIV_W'(SCAN_DIV - 1)) begin
        div_r <= '0;
        if (idx_r == IDX_W'(DIGITS - 1)) begin
          idx_r <= '0;
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end else begin
        div_r <= div_r + DIV_W'(1);
      end
    end
  end

  assign seg  = seg_r;
  assign an   = an_r;
  assign busy = busy_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed stimulus with a scoreboard; a negedge monitor
// pops the expected digits/ovf when busy falls and checks one full scan.
module tb_score_display;

  localparam int SCORE_W  = 14;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic               clk3 = 1'b0;
  logic               reset = 1'b0;
  logic [SCORE_W-1:0] score = '0;
  logic [6:0]         seg;
  logic [DIGITS-1:0]  an;
  logic               busy;
  logic               ovf;

  score_display #(.SCORE_W(SCORE_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk3(clk3), .reset(reset), .score(score),
    .seg(seg), .an(an), .busy(busy), .ovf(ovf)
  );

  always #5 clk3 = ~clk3;

  typedef struct packed {
    logic [15:0] digs;   // BCD nibbles, digit 3 in the top nibble
    logic        ov;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] digs, input logic ov, input int idx);
    logic [15:0] hi;
    hi = digs >> (4 * idx);
`ifdef LEADZERO_BLANK_EN
    if (!ov && idx != 0 && hi == 16'd0) return 7'h7F;
`endif
    return seg_ref(hi[3:0]);
  endfunction

  // Monitor state
  bit         cap_active = 1'b0;
  int         cap_n = 0;
  logic [6:0] cap_seg [0:3];
  exp_t       cur;
  bit         prev_busy = 1'b0;

  // Monitor: on each completed conversion check ovf, then one full scan of segs
  always @(negedge clk3) begin
    int ix;
    if (cap_active) begin
      case (an)
        4'b1110: ix = 0;
        4'b1101: ix = 1;
        4'b1011: ix = 2;
        4'b0111: ix = 3;
        default: ix = -1;
      endcase
      if (ix < 0) check("an_onehot", 16'(an), 16'h000E);
      else cap_seg[ix] = seg;
      cap_n++;
      if (cap_n == DIGITS * SCAN_DIV) begin
        for (int i = 0; i < DIGITS; i++)
          check($sformatf("seg_idx%0d", i), 16'(cap_seg[i]), 16'(exp_seg(cur.digs, cur.ov, i)));
        cap_active = 1'b0;
      end
    end
    if (reset && prev_busy && !busy) begin
      if (sb_q.size() == 0) begin
        check("unexpected_conversion", 16'd1, 16'd0);
      end else begin
        cur = sb_q.pop_front();
        check("ovf", 16'(ovf), 16'(cur.ov));
        for (int i = 0; i < DIGITS; i++) cap_seg[i] = 7'bx;
        cap_n = 0;
        cap_active = 1'b1;
      end
    end
    prev_busy = busy & reset;
  end

  // Change the score, expect one conversion, check busy stays high 15 cycles
  task automatic run_conv(input logic [SCORE_W-1:0] v, input logic [15:0] digs, input logic ov);
    int   hi;
    exp_t e;
    @(negedge clk3);
    e.digs = digs;
    e.ov   = ov;
    sb_q.push_back(e);
    score = v;
    hi = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk3);
      if (busy) hi++;
      else if (hi > 0) break;
    end
    check("busy_len", 16'(hi), 16'(SCORE_W + 1));
    repeat (20) @(negedge clk3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ea;
    bit         saw;
    int         cnt, falls, hi;
    bit         pb;
    exp_t       e;

    // Reset state
    repeat (3) @(negedge clk3);
    check("rst_seg", 16'(seg), 16'h007F);
    check("rst_an", 16'(an), 16'h000F);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_ovf", 16'(ovf), 16'd0);
    reset = 1'b1;

    // Score 0 after release: no conversion, scan order with 4-cycle dwell
    saw = 1'b0;
    for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
      @(negedge clk3);
      ea = 4'b1111;
      ea[k / SCAN_DIV] = 1'b0;
      check("scan_an", 16'(an), 16'(ea));
      check("scan_seg", 16'(seg), 16'(exp_seg(16'h0000, 1'b0, k / SCAN_DIV)));
      if (busy) saw = 1'b1;
    end
    repeat (8) begin
      @(negedge clk3);
      if (busy) saw = 1'b1;
    end
    check("idle_no_busy", 16'(saw), 16'd0);

    run_conv(14'd1234,  16'h1234, 1'b0);
    run_conv(14'd12000, 16'h9999, 1'b1);
    run_conv(14'd7,     16'h0007, 1'b0);

    // 5 then 6 three cycles into the conversion: two loads, bounded settle
    @(negedge clk3);
    e.ov = 1'b0;
    e.digs = 16'h0005; sb_q.push_back(e);
    e.digs = 16'h0006; sb_q.push_back(e);
    score = 14'd5;
    cnt = 0; falls = 0; pb = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk3);
      cnt++;
      if (cnt == 3) score = 14'd6;
      if (pb && !busy) falls++;
      pb = busy;
      if (falls == 2) break;
    end
    check("two_conversions", 16'(falls), 16'd2);
    check("settle_within_bound", 16'(cnt - 1 <= 2 * (SCORE_W + 1) + 1), 16'd1);
    repeat (20) @(negedge clk3);

    // Reset mid-conversion of 999, then the conversion restarts
    @(negedge clk3);
    score = 14'd999;
    repeat (5) @(negedge clk3);
    check("busy_before_abort", 16'(busy), 16'd1);
    reset = 1'b0;
    #1;
    check("abort_seg", 16'(seg), 16'h007F);
    check("abort_an", 16'(an), 16'h000F);
    check("abort_busy", 16'(busy), 16'd0);
    repeat (2) @(negedge clk3);
    e.ov = 1'b0; e.digs = 16'h0999; sb_q.push_back(e);
    reset = 1'b1;
    @(negedge clk3);
    check("post_rst_digit0", 16'(seg), 16'h0040);
    check("post_rst_an", 16'(an), 16'h000E);
    check("restart_busy", 16'(busy), 16'd1);
    hi = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk3);
      if (busy) hi++;
      else break;
    end
    check("restart_busy_len", 16'(hi), 16'(SCORE_W + 1));
    repeat (20) @(negedge clk3);

    run_conv(14'd40, 16'h0040, 1'b0);
    run_conv(14'd0,  16'h0000, 1'b0);

    check("sb_empty", 16'(sb_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
